// File: rtl/icache_refill_controller.sv
// Instruction-cache line refill sequencer: stalls fetch on a miss, pulls one line
// from instruction memory, writes it into the cache and replays held redirects.
module icache_refill_controller #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              cache_hit,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_valid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              pc_stall,
  output logic              pc_src_out,
  output logic [ADDR_W-1:0] pc_target_out,
  output logic              busy,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t              state, state_nxt;
  logic                miss;
  logic                pend;
  logic [ADDR_W-1:0]   pend_target;
  logic [ADDR_W-1:0]   line_addr;
  logic [LINE_W-1:0]   line_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A fresh redirect outranks a held one; either squashes the fetch this cycle.
  always_comb begin
    state_nxt     = state;
    miss          = 1'b0;
    mem_req       = 1'b0;
    fill_en       = 1'b0;
    pc_stall      = 1'b0;
    pc_src_out    = 1'b0;
    pc_target_out = '0;
    case (state)
      IDLE: begin
        if (redirect) begin
          pc_src_out    = 1'b1;
          pc_target_out = redirect_target;
        end else if (pend) begin
          pc_src_out    = 1'b1;
          pc_target_out = pend_target;
        end else if (fetch_valid && !cache_hit) begin
          miss      = 1'b1;
          pc_stall  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        pc_stall = 1'b1;
        if (mem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        pc_stall = 1'b1;
        if (mem_valid) state_nxt = FILL;
      end
      FILL: begin
        pc_stall  = 1'b1;
        fill_en   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_addr  = line_addr;
  assign fill_addr = line_addr;
  assign fill_data = line_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr   <= '0;
      line_data   <= '0;
      miss_count  <= '0;
      pend        <= 1'b0;
      pend_target <= '0;
    end else begin
      if (miss) begin
        line_addr <= {fetch_addr[ADDR_W-1:3], 3'b000};
        if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
      end
      if (state == WAIT && mem_valid) line_data <= mem_rdata;
      // Redirects during a refill are held (last wins) and consumed back in IDLE.
      if (state == IDLE) begin
        pend <= 1'b0;
      end else if (redirect) begin
        pend        <= 1'b1;
        pend_target <= redirect_target;
      end
    end
  end

endmodule
